mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 184 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
// MEM-stage data-memory access controller. Consumes the EX/MEM register,
// runs a req/ready handshake with data memory, stalls the pipeline for the
// duration of the access, aligns store data onto byte lanes and
// extracts/extends load data.
//
// Ports:
//   Clk, Rst            clock, synchronous active-high reset
//   MemRead_in          load request from EX/MEM
//   MemWrite_in         store request (wins over MemRead_in)
//   MEMop_in[3:0]       0 word, 1 half s, 2 half u, 3 byte s, 4 byte u, else word
//   ALU_in[31:0]        byte address
//   Read2_in[31:0]      store data
//   Stall               freeze upstream stages (combinational)
//   LoadData[31:0]      extended load result, updated on completion of a load
//   AddrErr             one-cycle misalignment pulse
//   BusErr              one-cycle watchdog timeout pulse
//   mem_req, mem_we     request strobe and write enable
//   mem_addr[31:0]      word-aligned address
//   mem_wdata[31:0]     lane-replicated store data
//   mem_be[3:0]         byte enables
//   mem_ready           memory completion
//   mem_rdata[31:0]     read word, valid with mem_ready
//
// Build option: define MEM_TIMEOUT_EN to enable the BUSY watchdog
// (limit TIMEOUT_CYCLES). Without it BUSY waits indefinitely, BusErr is 0.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [3:0]  MEMop_in,
  input  logic [31:0] ALU_in,
  input  logic [31:0] Read2_in,
  output logic        Stall,
  output logic [31:0] LoadData,
  output logic        AddrErr,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t state_reg, state_next;

  // Request decode
  logic is_half, is_byte, access, misaligned, start, finish, timeout;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  assign is_half    = (MEMop_in == 4'b0001) || (MEMop_in == 4'b0010);
  assign is_byte    = (MEMop_in == 4'b0011) || (MEMop_in == 4'b0100);
  assign access     = MemRead_in | MemWrite_in;
  assign misaligned = is_byte ? 1'b0 : (is_half ? ALU_in[0] : (ALU_in[1:0] != 2'b00));
  assign start      = (state_reg == IDLE) && access && !misaligned;
  assign finish     = (state_reg == BUSY) && (mem_ready || timeout);

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = Read2_in;
    if (is_byte) begin
      be_next    = 4'b0001 << ALU_in[1:0];
      wdata_next = {4{Read2_in[7:0]}};
    end else if (is_half) begin
      be_next    = ALU_in[1] ? 4'b1100 : 4'b0011;
      wdata_next = {2{Read2_in[15:0]}};
    end
  end

  // Access attributes latched at issue; load extraction uses these, not the
  // live EX/MEM inputs.
  logic       rd_reg;
  logic [3:0] op_reg;
  logic [1:0] lane_reg;

  // Load lane extraction
  logic [7:0]  rd_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_ext;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_byte[gi] = mem_rdata[8*gi +: 8];
  end

  assign sel_byte = rd_byte[lane_reg];
  assign sel_half = lane_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_ext = mem_rdata;
    case (op_reg)
      4'b0001: load_ext = {{16{sel_half[15]}}, sel_half};
      4'b0010: load_ext = {16'h0000, sel_half};
      4'b0011: load_ext = {{24{sel_byte[7]}}, sel_byte};
      4'b0100: load_ext = {24'h000000, sel_byte};
      default: load_ext = mem_rdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt_reg;

  // Fires in the BUSY cycle that would bring the count to the limit; a
  // mem_ready in that same cycle takes precedence.
  assign timeout = (state_reg == BUSY) && !mem_ready &&
                   (tmo_cnt_reg == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk) begin
    if (Rst || start) begin
      tmo_cnt_reg <= '0;
    end else if ((state_reg == BUSY) && !mem_ready) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)  state_next = BUSY;
      BUSY:    if (finish) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    Stall = !Rst && (start || (state_reg == BUSY));
  end

  // Registered memory-side outputs and load result
  always_ff @(posedge Clk) begin
    if (Rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      LoadData  <= '0;
      AddrErr   <= 1'b0;
      BusErr    <= 1'b0;
      rd_reg    <= 1'b0;
      op_reg    <= '0;
      lane_reg  <= '0;
    end else begin
      AddrErr <= (state_reg == IDLE) && access && misaligned;
      BusErr  <= timeout;
      if (start) begin
        mem_req   <= 1'b1;
        mem_we    <= MemWrite_in;
        mem_addr  <= {ALU_in[31:2], 2'b00};
        mem_wdata <= wdata_next;
        mem_be    <= be_next;
        rd_reg    <= MemRead_in && !MemWrite_in;
        op_reg    <= MEMop_in;
        lane_reg  <= ALU_in[1:0];
      end else if (finish) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (mem_ready && rd_reg) LoadData <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        MemRead_in, MemWrite_in;
  logic [3:0]  MEMop_in;
  logic [31:0] ALU_in, Read2_in;
  logic        Stall;
  logic [31:0] LoadData;
  logic        AddrErr, BusErr;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic [31:0] ld;
  } exp_t;

  exp_t sb_q[$];

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .MEMop_in(MEMop_in),
    .ALU_in(ALU_in), .Read2_in(Read2_in),
    .Stall(Stall), .LoadData(LoadData), .AddrErr(AddrErr), .BusErr(BusErr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one aligned access at a negedge, answer it after `waits` BUSY
  // cycles, and check request fields, stall length and load result.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] r2, input logic [31:0] rdata,
                            input int waits, input logic [31:0] e_addr,
                            input logic [3:0] e_be, input logic [31:0] e_wdata,
                            input logic [31:0] e_ld);
    exp_t e, got;
    int   stalls;
    e.addr = e_addr; e.wdata = e_wdata; e.be = e_be; e.we = wr; e.ld = e_ld;
    sb_q.push_back(e);
    MemRead_in = rd; MemWrite_in = wr; MEMop_in = op; ALU_in = addr; Read2_in = r2;
    #1;
    stalls = Stall ? 1 : 0;
    check_val({tag, "_stall_idle"}, Stall, 1);
    @(negedge Clk);
    check_val({tag, "_sb_nonempty"}, sb_q.size() != 0, 1);
    if (sb_q.size() == 0) return;
    got = sb_q.pop_front();
    check_val({tag, "_req"},   mem_req,   1);
    check_val({tag, "_we"},    mem_we,    got.we);
    check_val({tag, "_addr"},  mem_addr,  got.addr);
    check_val({tag, "_be"},    mem_be,    got.be);
    check_val({tag, "_wdata"}, mem_wdata, got.wdata);
    for (int w = 0; w <= waits; w++) begin
      if (Stall) stalls++;
      if (w > 0) check_val({tag, "_req_hold"}, {mem_req, mem_we, mem_be}, {1'b1, got.we, got.be});
      if (w == waits) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
      end
      @(negedge Clk);
    end
    // DONE cycle
    check_val({tag, "_stall_done"}, Stall, 0);
    check_val({tag, "_req_done"}, mem_req, 0);
    check_val({tag, "_loaddata"}, LoadData, got.ld);
    mem_ready = 1'b0; mem_rdata = 32'h0;
    MemRead_in = 1'b0; MemWrite_in = 1'b0;
    @(negedge Clk);
    check_val({tag, "_stall_cycles"}, stalls, waits + 2);
    $display("txn %s addr=%h be=%b wdata=%h LoadData=%h stalls=%0d",
             tag, got.addr, got.be, got.wdata, LoadData, stalls);
  endtask

  initial begin
    Rst = 1'b1; MemRead_in = 0; MemWrite_in = 0; MEMop_in = 0;
    ALU_in = 0; Read2_in = 0; mem_ready = 0; mem_rdata = 0;
    repeat (3) @(negedge Clk);
    // Reset state
    check_val("rst_req", {mem_req, mem_we, AddrErr, BusErr}, 4'b0000);
    check_val("rst_addr", mem_addr, 0);
    check_val("rst_wdata", mem_wdata, 0);
    check_val("rst_be", mem_be, 0);
    check_val("rst_loaddata", LoadData, 0);
    MemRead_in = 1; ALU_in = 32'h100;
    #1 check_val("rst_stall", Stall, 0);
    $display("txn reset state");

    // Reset while BUSY: abandons the access, LoadData untouched
    Rst = 1'b0;
    @(negedge Clk);
    check_val("rb_stall_idle", Stall, 1);
    @(negedge Clk);
    check_val("rb_req", mem_req, 1);
    @(negedge Clk);
    Rst = 1'b1;
    #1 check_val("rb_stall_rst", Stall, 0);
    @(negedge Clk);
    check_val("rb_req_after", mem_req, 0);
    check_val("rb_loaddata", LoadData, 0);
    Rst = 1'b0; MemRead_in = 0; mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    repeat (2) @(negedge Clk);
    check_val("rb_ready_ignored", {mem_req, Stall}, 2'b00);
    check_val("rb_loaddata_late", LoadData, 0);
    mem_ready = 0; mem_rdata = 0;
    $display("txn reset in BUSY");

    //         tag    rd wr op       addr          r2            rdata         w  e_addr        be       wdata         ld
    run_access("lw",  1, 0, 4'b0000, 32'h00000100, 32'h0,        32'hDEADBEEF, 2, 32'h00000100, 4'b1111, 32'h0,        32'hDEADBEEF);
    run_access("lb",  1, 0, 4'b0011, 32'h00000103, 32'h0,        32'h80FF0000, 0, 32'h00000100, 4'b1000, 32'h0,        32'hFFFFFF80);
    run_access("lbu", 1, 0, 4'b0100, 32'h00000103, 32'h0,        32'h80FF0000, 0, 32'h00000100, 4'b1000, 32'h0,        32'h00000080);
    run_access("lh",  1, 0, 4'b0001, 32'h00000102, 32'h0,        32'h80FF0000, 1, 32'h00000100, 4'b1100, 32'h0,        32'hFFFF80FF);
    run_access("lhu", 1, 0, 4'b0010, 32'h00000100, 32'h0,        32'h80FF7F01, 0, 32'h00000100, 4'b0011, 32'h0,        32'h00007F01);
    run_access("sb",  0, 1, 4'b0011, 32'h00000201, 32'h123456AB, 32'h0,        1, 32'h00000200, 4'b0010, 32'hABABABAB, 32'h00007F01);
    run_access("sh",  0, 1, 4'b0001, 32'h00000206, 32'h0000BEEF, 32'h0,        0, 32'h00000204, 4'b1100, 32'hBEEFBEEF, 32'h00007F01);
    run_access("sw",  0, 1, 4'b0000, 32'h0000030C, 32'hCAFEF00D, 32'h0,        3, 32'h0000030C, 4'b1111, 32'hCAFEF00D, 32'h00007F01);
    run_access("rdwr",1, 1, 4'b0000, 32'h00000400, 32'h11223344, 32'h55555555, 0, 32'h00000400, 4'b1111, 32'h11223344, 32'h00007F01);
    run_access("op7", 1, 0, 4'b0111, 32'h00000404, 32'h0,        32'h0BADF00D, 0, 32'h00000404, 4'b1111, 32'h0,        32'h0BADF00D);

    // Misaligned word and half: one-cycle AddrErr, no request, no stall
    MemRead_in = 1; MEMop_in = 4'b0000; ALU_in = 32'h102;
    #1 check_val("mw_stall", Stall, 0);
    @(negedge Clk);
    check_val("mw_addrerr", AddrErr, 1);
    check_val("mw_req", mem_req, 0);
    MemRead_in = 0;
    @(negedge Clk);
    check_val("mw_addrerr_off", AddrErr, 0);
    $display("txn misaligned word addr=00000102");
    MemWrite_in = 1; MEMop_in = 4'b0001; ALU_in = 32'h101;
    #1 check_val("mh_stall", Stall, 0);
    @(negedge Clk);
    check_val("mh_addrerr", AddrErr, 1);
    check_val("mh_req", mem_req, 0);
    MemWrite_in = 0;
    @(negedge Clk);
    check_val("mh_addrerr_off", AddrErr, 0);
    check_val("mh_loaddata", LoadData, 32'h0BADF00D);
    $display("txn misaligned half addr=00000101");

`ifdef MEM_TIMEOUT_EN
    // Watchdog: 4 BUSY cycles with no ready -> DONE with BusErr
    MemRead_in = 1; MEMop_in = 4'b0000; ALU_in = 32'h500;
    @(negedge Clk);
    for (int i = 0; i < 4; i++) begin
      check_val("to_busy", {mem_req, Stall, BusErr}, 3'b110);
      @(negedge Clk);
    end
    check_val("to_buserr", BusErr, 1);
    check_val("to_stall_done", Stall, 0);
    check_val("to_req_done", mem_req, 0);
    check_val("to_loaddata", LoadData, 32'h0BADF00D);
    MemRead_in = 0;
    @(negedge Clk);
    check_val("to_buserr_off", BusErr, 0);
    $display("txn watchdog timeout addr=00000500");
`else
    // No watchdog: BUSY holds as long as ready stays low
    MemRead_in = 1; MEMop_in = 4'b0000; ALU_in = 32'h500;
    @(negedge Clk);
    for (int i = 0; i < 20; i++) begin
      check_val("nt_busy", {mem_req, Stall, BusErr}, 3'b110);
      @(negedge Clk);
    end
    mem_ready = 1; mem_rdata = 32'h600DF00D;
    @(negedge Clk);
    check_val("nt_loaddata", LoadData, 32'h600DF00D);
    check_val("nt_buserr", BusErr, 0);
    mem_ready = 0; MemRead_in = 0;
    @(negedge Clk);
    $display("txn long wait addr=00000500 LoadData=%h", LoadData);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
